// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator: issues one ACE snoop on AC at a time, gathers the CR response and any CD line,
// and returns a single consolidated result to the coherence controller.
module ace_snoop_initiator #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineBytes = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [3:0]             req_snoop_i,
   input  logic [2:0]             req_prot_i,
   output logic                   ac_valid_o,
   input  logic                   ac_ready_i,
   output logic [AddrWidth-1:0]   ac_addr_o,
   output logic [3:0]             ac_snoop_o,
   output logic [2:0]             ac_prot_o,
   input  logic                   cr_valid_i,
   output logic                   cr_ready_o,
   input  logic [4:0]             cr_resp_i,
   input  logic                   cd_valid_i,
   output logic                   cd_ready_o,
   input  logic [DataWidth-1:0]   cd_data_i,
   input  logic                   cd_last_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [4:0]             rsp_crresp_o,
   output logic [LineBytes*8-1:0] rsp_data_o,
   output logic                   rsp_has_data_o,
   output logic                   rsp_err_o
);
   localparam int LineBits = LineBytes * 8;
   localparam int Beats = LineBits / DataWidth;
   localparam int CntW = $clog2(Beats + 1);
   localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);
   typedef enum logic [1:0] {IDLE, AC, COLLECT, RSP} state_t;
   state_t state;
   logic [CntW-1:0] cnt;
   logic cr_done, cd_done;
   logic cr_hs, cd_hs, last_idx, cr_done_n, cd_done_n, dt_n, has_n, err_n, fin;
   // Next-cycle view of the collect flags so completion is decided on the handshake edge itself
   always_comb begin
      cr_hs     = cr_valid_i & cr_ready_o;
      cd_hs     = cd_valid_i & cd_ready_o;
      last_idx  = cnt == LastIdx;
      cr_done_n = cr_done | cr_hs;
      dt_n      = cr_hs ? cr_resp_i[0] : rsp_crresp_o[0];
      cd_done_n = cd_done | (cd_hs & (cd_last_i | last_idx));
      has_n     = rsp_has_data_o | cd_hs;
      err_n     = rsp_err_o | (cd_hs & (cd_last_i != last_idx)) | (cr_hs & cr_resp_i[1])
                  | (cr_done_n & !dt_n & has_n);
      fin       = cr_done_n & (!dt_n | cd_done_n);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         req_ready_o    <= 1'b0;
         ac_valid_o     <= 1'b0;
         cr_ready_o     <= 1'b0;
         cd_ready_o     <= 1'b0;
         rsp_valid_o    <= 1'b0;
         ac_addr_o      <= '0;
         ac_snoop_o     <= '0;
         ac_prot_o      <= '0;
         rsp_crresp_o   <= '0;
         rsp_data_o     <= '0;
         rsp_has_data_o <= 1'b0;
         rsp_err_o      <= 1'b0;
         cnt            <= '0;
         cr_done        <= 1'b0;
         cd_done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  ac_addr_o      <= req_addr_i;
                  ac_snoop_o     <= req_snoop_i;
                  ac_prot_o      <= req_prot_i;
                  rsp_crresp_o   <= '0;
                  rsp_data_o     <= '0;
                  rsp_has_data_o <= 1'b0;
                  rsp_err_o      <= 1'b0;
                  cnt            <= '0;
                  cr_done        <= 1'b0;
                  cd_done        <= 1'b0;
                  req_ready_o    <= 1'b0;
                  ac_valid_o     <= 1'b1;
                  state          <= AC;
               end else begin
                  req_ready_o <= 1'b1;
               end
            end
            AC: begin
               if (ac_ready_i) begin
                  ac_valid_o <= 1'b0;
                  cr_ready_o <= 1'b1;
                  cd_ready_o <= 1'b1;
                  state      <= COLLECT;
               end
            end
            COLLECT: begin
               if (cr_hs) rsp_crresp_o <= cr_resp_i;
               if (cd_hs) begin
                  rsp_data_o[cnt*DataWidth +: DataWidth] <= cd_data_i;
                  cnt <= cnt + CntW'(1);
               end
               cr_done        <= cr_done_n;
               cd_done        <= cd_done_n;
               rsp_has_data_o <= has_n;
               rsp_err_o      <= err_n;
               cr_ready_o     <= !fin && !cr_done_n;
               cd_ready_o     <= !fin && !cd_done_n;
               if (fin) begin
                  rsp_valid_o <= 1'b1;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb_ace_snoop_initiator: directed snoops with expected AC fields and results queued by the driver
// and checked by a separate negedge monitor.
module tb_ace_snoop_initiator;
   logic         clk_i = 1'b0, rst_i = 1'b1;
   logic         req_valid_i = 1'b0, req_ready_o;
   logic [63:0]  req_addr_i = '0;
   logic [3:0]   req_snoop_i = '0;
   logic [2:0]   req_prot_i = '0;
   logic         ac_valid_o, ac_ready_i = 1'b1;
   logic [63:0]  ac_addr_o;
   logic [3:0]   ac_snoop_o;
   logic [2:0]   ac_prot_o;
   logic         cr_valid_i = 1'b0, cr_ready_o;
   logic [4:0]   cr_resp_i = '0;
   logic         cd_valid_i = 1'b0, cd_ready_o, cd_last_i = 1'b0;
   logic [63:0]  cd_data_i = '0;
   logic         rsp_valid_o, rsp_ready_i = 1'b1;
   logic [4:0]   rsp_crresp_o;
   logic [127:0] rsp_data_o;
   logic         rsp_has_data_o, rsp_err_o;

   ace_snoop_initiator dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_snoop_i(req_snoop_i), .req_prot_i(req_prot_i),
      .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
      .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
      .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
      .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_crresp_o(rsp_crresp_o),
      .rsp_data_o(rsp_data_o), .rsp_has_data_o(rsp_has_data_o), .rsp_err_o(rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [63:0] addr; logic [3:0] snoop; logic [2:0] prot; } ac_t;
   typedef struct { logic [4:0] crresp; logic [127:0] data; logic has; logic err; int lat; } rsp_t;
   ac_t  ac_q[$];
   rsp_t rsp_q[$];
   int   passed = 0, total = 0, edges = 0, acc_edge = 0, first_edge = 0;

   always @(posedge clk_i) edges <= edges + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: pops expectations on AC and result handshakes, and checks stability while stalled
   logic         ac_hold = 1'b0, rsp_hold = 1'b0, rsp_prev = 1'b0;
   logic [70:0]  ac_last;
   logic [134:0] rsp_last;
   ac_t          ea;
   rsp_t         er;
   always @(negedge clk_i) begin
      if (rst_i) begin
         ac_hold = 1'b0; rsp_hold = 1'b0; rsp_prev = 1'b0;
      end else begin
         if (ac_valid_o) begin
            if (ac_hold) chk("ac_stable", {ac_addr_o, ac_snoop_o, ac_prot_o}, ac_last);
            ac_last = {ac_addr_o, ac_snoop_o, ac_prot_o};
            ac_hold = !ac_ready_i;
            if (ac_ready_i) begin
               if (ac_q.size() == 0) chk("ac_unexpected", 1, 0);
               else begin
                  ea = ac_q.pop_front();
                  chk("ac_fields", {ac_addr_o, ac_snoop_o, ac_prot_o}, {ea.addr, ea.snoop, ea.prot});
               end
            end
         end else ac_hold = 1'b0;
         if (rsp_valid_o && !rsp_prev) first_edge = edges;
         rsp_prev = rsp_valid_o;
         if (rsp_valid_o) begin
            if (rsp_hold) chk("rsp_stable", {rsp_crresp_o, rsp_data_o, rsp_has_data_o, rsp_err_o}, rsp_last);
            rsp_last = {rsp_crresp_o, rsp_data_o, rsp_has_data_o, rsp_err_o};
            rsp_hold = !rsp_ready_i;
            if (rsp_ready_i) begin
               if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  er = rsp_q.pop_front();
                  chk("rsp_crresp", rsp_crresp_o, er.crresp);
                  chk("rsp_data", rsp_data_o, er.data);
                  chk("rsp_has_data", rsp_has_data_o, er.has);
                  chk("rsp_err", rsp_err_o, er.err);
                  if (er.lat != 0) chk("rsp_latency", first_edge - acc_edge + 1, er.lat);
               end
            end
         end else rsp_hold = 1'b0;
      end
   end

   task automatic do_req(input logic [63:0] a, input logic [3:0] s, input logic [2:0] p);
      ac_t t;
      int n = 0;
      t.addr = a; t.snoop = s; t.prot = p;
      ac_q.push_back(t);
      req_valid_i = 1'b1; req_addr_i = a; req_snoop_i = s; req_prot_i = p;
      do begin @(negedge clk_i); n++; end while (!req_ready_o && n < 20);
      chk("req_ready_wait", req_ready_o, 1);
      @(posedge clk_i); #1;
      acc_edge = edges;
      req_valid_i = 1'b0;
   endtask

   task automatic issue(input logic [63:0] a, input logic [3:0] s, input logic [2:0] p, input int stall);
      int n = 0;
      ac_ready_i = (stall == 0);
      do_req(a, s, p);
      if (stall > 0) begin
         repeat (stall) @(posedge clk_i);
         #1 ac_ready_i = 1'b1;
      end
      do begin @(negedge clk_i); n++; end while (!ac_valid_o && n < 20);
      chk("ac_wait", ac_valid_o, 1);
      @(posedge clk_i); #1;
   endtask

   task automatic expect_rsp(input logic [4:0] c, input logic [127:0] d, input logic h, input logic e, input int lat);
      rsp_t t;
      t.crresp = c; t.data = d; t.has = h; t.err = e; t.lat = lat;
      rsp_q.push_back(t);
   endtask

   task automatic cr(input logic [4:0] r);
      int n = 0;
      cr_valid_i = 1'b1; cr_resp_i = r;
      do begin @(negedge clk_i); n++; end while (!cr_ready_o && n < 20);
      chk("cr_wait", cr_ready_o, 1);
      @(posedge clk_i); #1 cr_valid_i = 1'b0;
   endtask

   task automatic cd(input logic [63:0] d, input logic l);
      int n = 0;
      cd_valid_i = 1'b1; cd_data_i = d; cd_last_i = l;
      do begin @(negedge clk_i); n++; end while (!cd_ready_o && n < 20);
      chk("cd_wait", cd_ready_o, 1);
      @(posedge clk_i); #1 cd_valid_i = 1'b0;
   endtask

   task automatic cd_cr(input logic [63:0] d, input logic l, input logic [4:0] r);
      int n = 0;
      cd_valid_i = 1'b1; cd_data_i = d; cd_last_i = l;
      cr_valid_i = 1'b1; cr_resp_i = r;
      do begin @(negedge clk_i); n++; end while (!(cd_ready_o && cr_ready_o) && n < 20);
      chk("cd_cr_wait", {cd_ready_o, cr_ready_o}, 2'b11);
      @(posedge clk_i); #1;
      cd_valid_i = 1'b0; cr_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin @(negedge clk_i); n++; end while (rsp_q.size() != 0 && n < 100);
      chk("rsp_done", rsp_q.size(), 0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_valids", {ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o}, 0);
      chk("rst_rsp", {rsp_crresp_o, rsp_data_o, rsp_has_data_o, rsp_err_o}, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      chk("idle_req_ready", req_ready_o, 1);
      // ReadShared with a two-beat line after CR
      issue(64'h8000_0040, 4'b0001, 3'b010, 0);
      expect_rsp(5'b00001, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b1, 1'b0, 5);
      cr(5'b00001);
      cd(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      cd(64'hBBBB_BBBB_BBBB_BBBB, 1'b1);
      wait_done();
      // CleanInvalid, no data, minimum latency
      issue(64'h0000_1234_5600, 4'b1001, 3'b000, 0);
      expect_rsp(5'b00000, 128'h0, 1'b0, 1'b0, 3);
      cr(5'b00000);
      wait_done();
      // AC stalled 4 cycles, line delivered before CR
      issue(64'hFFFF_0000_C0DE_0080, 4'b0111, 3'b101, 4);
      expect_rsp(5'b00101, {64'hC1C1_0000_1111_C1C1, 64'hC0C0_2222_0000_C0C0}, 1'b1, 1'b0, 0);
      cd(64'hC0C0_2222_0000_C0C0, 1'b0);
      cd(64'hC1C1_0000_1111_C1C1, 1'b1);
      cr(5'b00101);
      wait_done();
      // Early last on the first beat
      issue(64'h0000_0000_0000_1100, 4'b0001, 3'b000, 0);
      expect_rsp(5'b00001, {64'h0, 64'hD0D0_D0D0_1234_5678}, 1'b1, 1'b1, 0);
      cd(64'hD0D0_D0D0_1234_5678, 1'b1);
      cr(5'b00001);
      wait_done();
      // CR together with the final beat, result held by consumer
      rsp_ready_i = 1'b0;
      issue(64'h0000_0000_ABCD_0000, 4'b0010, 3'b011, 0);
      expect_rsp(5'b10001, {64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0}, 1'b1, 1'b0, 4);
      cd(64'hE0E0_E0E0_E0E0_E0E0, 1'b0);
      cd_cr(64'hE1E1_E1E1_E1E1_E1E1, 1'b1, 5'b10001);
      chk("rsp_valid_up", rsp_valid_o, 1);
      repeat (3) begin
         @(posedge clk_i); #1;
         chk("req_ready_hold", {req_ready_o, rsp_valid_o}, 2'b01);
      end
      rsp_ready_i = 1'b1;
      wait_done();
      chk("req_ready_after_rsp", req_ready_o, 1);
      chk("rsp_data_kept", {rsp_data_o, rsp_has_data_o}, {64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0, 1'b1});
      // Async reset in the middle of collection
      issue(64'h0000_0000_0F0F_0000, 4'b0001, 3'b000, 0);
      cd(64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
      rst_i = 1'b1;
      #1;
      chk("arst_valids", {req_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o}, 0);
      chk("arst_rsp", {rsp_crresp_o, rsp_data_o, rsp_has_data_o, rsp_err_o}, 0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(posedge clk_i); #1;
      issue(64'h0000_0000_0000_2200, 4'b1000, 3'b000, 0);
      expect_rsp(5'b00000, 128'h0, 1'b0, 1'b0, 3);
      cr(5'b00000);
      wait_done();
      // Error bit in CR
      issue(64'h0000_0000_0000_3300, 4'b0001, 3'b000, 0);
      expect_rsp(5'b00010, 128'h0, 1'b0, 1'b1, 3);
      cr(5'b00010);
      wait_done();
      // Data beat seen but CR says no data transfer
      issue(64'h0000_0000_0000_4400, 4'b0001, 3'b000, 0);
      expect_rsp(5'b00000, {64'h0, 64'h1234_5678_9ABC_DEF0}, 1'b1, 1'b1, 0);
      cd(64'h1234_5678_9ABC_DEF0, 1'b0);
      cr(5'b00000);
      wait_done();
      chk("ac_queue_empty", ac_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ace_snoop_initiator.md
Name: ace_snoop_initiator

Overview:
- Interconnect-side initiator for the ACE snoop channels (AC out; CR and CD in).
- Accepts one snoop request at a time from the coherence controller and issues it on AC.
- Collects the CR response and, when data is transferred, the full cache line on CD.
- Returns one consolidated result (crresp, line data, error flag) to the controller.

Parameters:
- AddrWidth, 64, width of AC address and request address.
- DataWidth, 64, CD beat width in bits.
- LineBytes, 16, cache line size; Beats = LineBytes*8/DataWidth (must be an integer ≥1; default 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  snoop request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  AddrWidth  snoop address.
- req_snoop_i  in  4  acsnoop code.
- req_prot_i  in  3  acprot.
- ac_valid_o  out  1  AC valid.
- ac_ready_i  in  1  AC ready.
- ac_addr_o  out  AddrWidth  AC address.
- ac_snoop_o  out  4  AC snoop.
- ac_prot_o  out  3  AC prot.
- cr_valid_i  in  1  CR valid.
- cr_ready_o  out  1  CR ready.
- cr_resp_i  in  5  crresp {WasUnique, IsShared, PassDirty, Error, DataTransfer}; bit0 = DataTransfer.
- cd_valid_i  in  1  CD valid.
- cd_ready_o  out  1  CD ready.
- cd_data_i  in  DataWidth  CD beat.
- cd_last_i  in  1  CD last beat.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_crresp_o  out  5  captured crresp.
- rsp_data_o  out  LineBytes*8  assembled line.
- rsp_has_data_o  out  1  CD line received.
- rsp_err_o  out  1  protocol violation detected.

Behaviour:
- Reset (async, any state): state=IDLE, all valid/ready outputs 0, rsp_crresp_o=0, rsp_data_o=0, rsp_has_data_o=0, rsp_err_o=0, beat counter=0.
- FSM states: IDLE, AC, COLLECT, RSP.
- IDLE:
  - req_ready_o=1. On req handshake: register addr/snoop/prot; clear data, counter, flags, cr_done and cd_done; go to AC.
  - The first ac_valid_o is in the cycle after acceptance.
- AC:
  - ac_valid_o=1 with registered fields, held stable until ac_ready_i.
  - On handshake go to COLLECT.
- COLLECT:
  - cr_ready_o = !cr_done.
  - cd_ready_o = !cd_done. CD may arrive before, with, or after CR; beats are accepted regardless of order.
  - CR handshake: capture cr_resp_i into rsp_crresp_o; set cr_done.
  - CD handshake: write beat into rsp_data_o[cnt*DataWidth +: DataWidth]; cnt++; set rsp_has_data_o.
  - cd_done sets on a beat with cd_last_i=1, or on beat number Beats (cnt reaches Beats).
  - Set rsp_err_o on any of:
    - cd_last_i with cnt≠Beats-1;
    - Beats-th beat without cd_last_i;
    - cr_done with DataTransfer=0 while any CD beat has been accepted;
    - cr_resp_i Error bit=1.
  - Exit to RSP the cycle after the completion condition holds, including when CR and the final CD beat handshake in the same cycle. Completion condition: cr_done && (DataTransfer==0 || cd_done).
  - With DataTransfer=0, exit does not wait for CD. Further CD beats are not accepted (cd_ready_o=0 outside COLLECT).
- RSP:
  - rsp_valid_o=1; outputs held stable until rsp_ready_i.
  - On handshake go to IDLE. A new request is accepted no earlier than the next cycle (no back-to-back bypass).
  - rsp_* outputs keep their value until the next request is accepted.
- Minimum latency, with ac_ready and CR valid immediately and no data: req accept at T, ac handshake at T+1, CR at T+2, rsp_valid_o at T+3.
- No inputs are sampled outside their valid&ready handshake. Only one snoop is outstanding at a time.

Test Plan:
- ReadShared snoop (req_snoop=0001, addr 0x8000_0040), ac_ready high; CR=5'b00001, CD beats 0xAAAA… then 0xBBBB… with last on beat 2 -> rsp_valid at T+5, rsp_data_o={0xBBBB…,0xAAAA…}, has_data=1, err=0.
- CleanInvalid; CR=5'b00000, no CD -> rsp_valid at T+3, has_data=0, data=0, err=0.
- CD both beats delivered before CR=5'b00101, ac_ready delayed 4 cycles -> ac fields stable during stall, data assembled correctly, crresp=00101, err=0.
- CD last on beat 1 with Beats=2 -> err=1, has_data=1, completes after CR, upper half 0.
- CR and final CD beat in the same cycle; rsp_ready_i held low 3 cycles -> rsp outputs stable, req_ready_o=0 until the rsp handshake.
- rst_i asserted in COLLECT after 1 CD beat -> all outputs 0 immediately; after release a fresh snoop completes normally with no stale data.
